// File: rtl/vga_frame_reader.sv
// VGA timing generator and framebuffer reader. Streams an integer-scaled image window
// from data RAM to the VGA pins through a small prefetch FIFO with one read in flight.
module vga_frame_reader #(
  parameter int             S          = 32,
  parameter int             IMG_W      = 100,
  parameter int             IMG_H      = 100,
  parameter int             SCALE      = 4,
  parameter int             X0         = 120,
  parameter int             Y0         = 40,
  parameter logic [S-1:0]   BASE_ADDR  = '0,
  parameter int             FIFO_DEPTH = 8,
  parameter int             H_VIS      = 640,
  parameter int             H_FP       = 16,
  parameter int             H_SYNC     = 96,
  parameter int             H_BP       = 48,
  parameter int             V_VIS      = 480,
  parameter int             V_FP       = 10,
  parameter int             V_SYNC     = 2,
  parameter int             V_BP       = 33
) (
  input  logic         clk,
  input  logic         rst,
  output logic         fb_req,
  output logic [S-1:0] fb_addr,
  input  logic         fb_valid,
  input  logic [S-1:0] fb_data,
  output logic [23:0]  rgb,
  output logic         h_sync,
  output logic         v_sync,
  output logic         vga_clk,
  output logic         frame_start,
  output logic         underflow
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(IMG_W + 1);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_LSTART = HW'(H_VIS - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX0      = HW'(X0);
  localparam logic [HW-1:0] WX1      = HW'(X0 + IMG_W * SCALE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY0      = VW'(Y0);
  localparam logic [VW-1:0] WY1      = VW'(Y0 + IMG_H * SCALE);
  localparam logic [CW-1:0] COL_END  = CW'(IMG_W);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic          tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_next;
  logic          in_win;
  logic          line_start;
  logic [SW-1:0] hsub;
  logic [SW-1:0] fsub;
  logic [S-1:0]  row_addr;
  logic [1:0]    state;
  logic [CW-1:0] col;
  logic          discard;
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          fb_data_unused;

  assign vga_clk        = tick;
  assign fb_req         = (state == ST_REQ);
  assign fb_data_unused = ^fb_data[S-1:24];

  assign v_next     = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
  assign in_win     = (h_cnt >= WX0) && (h_cnt < WX1) && (v_cnt >= WY0) && (v_cnt < WY1);
  // Prefetch for the next line begins as soon as the visible part of this one ends.
  assign line_start = tick && (h_cnt == H_LSTART) && (v_next >= WY0) && (v_next < WY1);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign push       = (state == ST_WAIT) && fb_valid && !discard && !line_start;
  assign pop        = tick && in_win && !fifo_empty && (hsub == SUB_LAST);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      tick <= ~tick;
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= v_next;
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end
    end
  end

  // Outputs are computed from the current counters, so they trail them by one pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb         <= '0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      hsub        <= '0;
    end else begin
      frame_start <= tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (tick) begin
        h_sync <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        v_sync <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        if (in_win) begin
          rgb  <= fifo_empty ? 24'h0 : fifo_mem[rd_ptr];
          hsub <= (hsub == SUB_LAST) ? '0 : hsub + SW'(1);
          if (fifo_empty) underflow <= 1'b1;
        end else begin
          rgb  <= '0;
          hsub <= '0;
        end
      end
    end
  end

  // Row address tracking for the line being fetched: sub-line counter instead of a divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_addr <= BASE_ADDR;
      fsub     <= '0;
    end else if (line_start) begin
      if (v_next == WY0) begin
        row_addr <= BASE_ADDR;
        fsub     <= '0;
      end else if (fsub == SUB_LAST) begin
        row_addr <= row_addr + S'(IMG_W);
        fsub     <= '0;
      end else begin
        fsub <= fsub + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      col     <= COL_END;
      discard <= 1'b0;
      fb_addr <= BASE_ADDR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!line_start && (col < COL_END) && !fifo_full) begin
            state   <= ST_REQ;
            fb_addr <= row_addr + S'(col);
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
          if (line_start) discard <= 1'b1;
        end
        ST_WAIT: begin
          if (fb_valid) begin
            state   <= ST_IDLE;
            discard <= 1'b0;
            if (!discard && !line_start) col <= col + CW'(1);
          end else if (line_start) begin
            discard <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (line_start) col <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || line_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= fb_data[23:0];
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized bench for vga_frame_reader using a reduced raster, a latency-randomized
// memory model and a pixel/fetch reference derived from elapsed clock edges.
module tb_vga_frame_reader;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 24, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int IMG_W = 10, IMG_H = 5, SCALE = 2, X0 = 12, Y0 = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fb_req;
  logic [31:0] fb_addr;
  logic        fb_valid;
  logic [31:0] fb_data;
  logic [23:0] rgb;
  logic        h_sync, v_sync, vga_clk, frame_start, underflow;

  vga_frame_reader #(
    .S(32), .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .X0(X0), .Y0(Y0),
    .BASE_ADDR(BASE), .FIFO_DEPTH(4),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .fb_req(fb_req), .fb_addr(fb_addr), .fb_valid(fb_valid),
    .fb_data(fb_data), .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync), .vga_clk(vga_clk),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: e counts clk edges since reset release.
  int          e = 0;
  bit          outstanding = 0, stale = 0, fetch_clean = 1, ever_slow = 0;
  int          exp_col = IMG_W, exp_r = 0, wait_cnt = 0;
  int          lat_lo = 1, lat_hi = 2;
  logic [31:0] resp_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s e=%0d got=%h expected=%h", tag, e, got, exp);
    end
  endtask

  task automatic on_edge();
    bit rst_s, val_s;
    int q, h, v, vn;
    rst_s = rst;
    val_s = fb_valid;
    if (val_s && outstanding) begin
      outstanding = 0;
      if (stale || rst_s) stale = 0;
      else exp_col++;
    end
    if (rst_s) begin
      e = 0;
      exp_col = IMG_W;
      stale = outstanding;
      fetch_clean = 1;
      ever_slow = 0;
    end else begin
      e++;
      if (e >= 2 && e % 2 == 0) begin
        q = e / 2 - 1;
        h = q % HT;
        v = (q / HT) % VT;
        vn = (v + 1) % VT;
        if (h == HV - 1 && vn >= Y0 && vn < Y0 + IMG_H * SCALE) begin
          exp_col = 0;
          exp_r = (vn - Y0) / SCALE;
          stale = outstanding;
          fetch_clean = !outstanding && (lat_hi <= 2);
        end
      end
    end
  endtask

  task automatic on_negedge();
    int p, h, v, c, r, lat;
    bit act, inw, hs_act, vs_act, fs;
    logic [23:0] exp_rgb;
    logic [31:0] idx, exp_addr, rnd;
    act = (e >= 2);
    p = act ? e / 2 - 1 : 0;
    h = p % HT;
    v = (p / HT) % VT;
    inw = act && h >= X0 && h < X0 + IMG_W * SCALE && v >= Y0 && v < Y0 + IMG_H * SCALE;
    c = (h - X0) / SCALE;
    r = (v - Y0) / SCALE;
    exp_rgb = inw ? {c[7:0], r[7:0], 8'hA5} : 24'h0;
    hs_act = act && h >= HV + HF && h < HV + HF + HS;
    vs_act = act && v >= VV + VF && v < VV + VF + VS;
    fs = act && (e % 2 == 0) && ((e / 2) % FR == 0);

    check("vga_clk", 32'(vga_clk), 32'(e % 2));
    check("h_sync", 32'(h_sync), 32'(!hs_act));
    check("v_sync", 32'(v_sync), 32'(!vs_act));
    check("frame_start", 32'(frame_start), 32'(fs));
    if (inw && !fetch_clean)
      check("rgb_row", 32'((rgb == 24'h0) || (rgb[15:0] == {r[7:0], 8'hA5})), 32'd1);
    else
      check("rgb", 32'(rgb), 32'(exp_rgb));
    if (!ever_slow) check("underflow", 32'(underflow), 32'd0);
    if (e == 0) begin
      check("fb_req_rst", 32'(fb_req), 32'd0);
      check("fb_addr_rst", fb_addr, BASE);
    end

    rnd = $urandom;
    if (outstanding && wait_cnt == 0) begin
      fb_valid = 1'b1;
      fb_data  = resp_data;
    end else begin
      if (outstanding) wait_cnt--;
      fb_valid = 1'b0;
      fb_data  = rnd;
    end

    if (fb_req === 1'b1 && e > 0) begin
      check("req_legal", 32'((exp_col < IMG_W) && !outstanding), 32'd1);
      exp_addr = BASE + 32'(exp_r * IMG_W + exp_col);
      check("fb_addr", fb_addr, exp_addr);
      lat = $urandom_range(lat_hi, lat_lo);
      outstanding = 1;
      wait_cnt = lat - 1;
      if (lat > 2) begin
        fetch_clean = 0;
        ever_slow = 1;
      end
      idx = fb_addr - BASE;
      c = int'(idx % IMG_W);
      r = int'(idx / IMG_W);
      rnd = $urandom;
      resp_data = {rnd[7:0], c[7:0], r[7:0], 8'hA5};
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      on_edge();
      @(negedge clk);
      on_negedge();
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    fb_valid = 1'b0;
    fb_data = '0;
    run(3);
    rst = 1'b0;

    // Two full frames with 1..2 clk memory latency: exact pixels, syncs and addresses.
    run(2 * 2 * FR + 400);

    // Slow memory: FIFO starves, underflow latches, pixels degrade to 0 or same-row data.
    lat_lo = 30; lat_hi = 30;
    run(800);
    lat_lo = 1; lat_hi = 2;
    run(800);
    check("underflow_set", 32'(underflow), 32'd1);

    // Responses longer than a line: line start lands in WAIT and the late word is dropped.
    lat_lo = 100; lat_hi = 140;
    run(1200);
    lat_lo = 1; lat_hi = 2;
    run(2 * FR + 400);

    // Reset mid-window with a read outstanding; the late response must be ignored.
    lat_lo = 20; lat_hi = 20;
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      run(1);
      if (outstanding && e >= 2 && ((e / 2 - 1) / HT) % VT >= Y0 + 2 &&
          ((e / 2 - 1) / HT) % VT < Y0 + IMG_H * SCALE)
        found = 1;
    end
    check("rst_point_found", 32'(found), 32'd1);
    if (found) begin
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      lat_lo = 1; lat_hi = 2;
      run(2 * FR + 400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display back-end of the ASIP. It generates 640x480@60 Hz VGA timing from the 50 MHz system clock and streams a 24-bit RGB image out of the data RAM (the framebuffer written by the processor's store path) to the `rgb`/`h_sync`/`v_sync`/`vga_clk` pins. Image rows are prefetched through a small FIFO via a single-outstanding read handshake on a dedicated memory-controller read port. Each image pixel is scaled up by an integer factor inside a fixed screen window.

## Interface
- S, 32, framebuffer data/address width
- IMG_W, 100, image width in pixels (one RAM word per pixel)
- IMG_H, 100, image height in pixels
- SCALE, 4, integer replication factor (horizontal and vertical)
- X0, 120, first screen column of the image window
- Y0, 40, first screen line of the image window
- BASE_ADDR, 0, RAM word address of image pixel (0,0)
- FIFO_DEPTH, 8, prefetch FIFO entries (power of 2)

Ports:
- clk  in  1  50 MHz system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- fb_req  out  1  one-cycle read request
- fb_addr  out  S  word address, valid while fb_req=1
- fb_valid  in  1  read data valid, at least 1 cycle after fb_req
- fb_data  in  S  read data; pixel = fb_data[23:0] as {R,G,B}
- rgb  out  24  pixel colour
- h_sync  out  1  horizontal sync, active-low
- v_sync  out  1  vertical sync, active-low
- vga_clk  out  1  25 MHz pixel clock (clk/2)
- frame_start  out  1  one-clk pulse at start of each frame
- underflow  out  1  sticky: a displayed pixel found the FIFO empty

## Operation
- Pixel tick: a toggle register `tick` drives vga_clk (reset 0). Counters advance only on clk cycles where tick=1.
- h_cnt 0..799: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799. v_cnt 0..524: visible 0-479, FP 480-489, sync 490-491, BP 492-524. v_cnt increments when h_cnt wraps 799->0. Both counters wrap to 0 at (799,524).
- h_sync=0 iff h_cnt in 656-751. v_sync=0 iff v_cnt in 490-491.
- Window: h in [X0, X0+IMG_W*SCALE), v in [Y0, Y0+IMG_H*SCALE). Outside the window or in blanking, rgb=0.
- Line v inside the window shows image row r=floor((v-Y0)/SCALE). Image column c covers SCALE consecutive pixels. Use row/sub-line counters; no divider.
- Line start event: on the tick where h_cnt goes 639->640, if the next line (v+1, wrapping 524->0) is a window line, the block:
  - flushes the FIFO;
  - sets the fetch column to 0 and the row address to BASE_ADDR + r*IMG_W;
  - marks any in-flight response as discard.
- Fetch FSM states:
  - IDLE: if fetch column < IMG_W and FIFO has ≥1 free slot, go to REQ.
  - REQ: assert fb_req for one cycle with fb_addr = row address + column; go to WAIT.
  - WAIT: on fb_valid, push fb_data[23:0] (unless the discard flag is set, in which case drop it and clear the flag), increment the column, go to IDLE.
  - At most one request is outstanding.
- Pop: on window pixels, rgb = FIFO head. The head is popped on the last (SCALE-th) repeat of each image column. If the FIFO is empty when a window pixel is shown: rgb=0, no pop, underflow is set (cleared only by rst).
- Arithmetic: fb_addr computed modulo 2^S. FIFO push and pop in the same cycle is legal; count is unchanged.

## Timing
- Reset values: tick=0, vga_clk=0, h_cnt=v_cnt=0, h_sync=1, v_sync=1, rgb=0, fb_req=0, fb_addr=BASE_ADDR, frame_start=0, underflow=0, FIFO empty, FSM IDLE.
- Outputs rgb/h_sync/v_sync are registered and updated on tick cycles. They reflect the counter value of the previous tick (latency 1 pixel = 2 clk) and stay mutually aligned.
- frame_start pulses on the tick cycle where counters wrap to (0,0).
- Minimum fetch throughput is 1 word per 3 clk. Consumption is 1 word per 2*SCALE clk. 160 blanking pixels of prefetch fill the FIFO before X0 when fb_valid latency ≤ 20 clk.
- rst asserted mid-frame or mid-fetch returns all state to reset values on the next edge. An fb_valid arriving after reset is ignored.

## Test plan
- Reset, then 2 frames with fb_valid 1 clk after fb_req: vga_clk period 2 clk; h_sync low 96 ticks every 800; v_sync low 2 lines every 525; frame_start every 840000 clk.
- Line Y0=40 prefetch: first fb_addr=0 issued during line 39 hblank. Line 44 fetches 100..199. Line 439 fetches 9900..9999. No requests for lines ≥440.
- Framebuffer pixel(c,r)={c[7:0],r[7:0],8'hA5}: screen (120..123, 40) = 24'h0000A5; (124, 43) = 24'h0100A5; (519, 439) = 24'h6363A5. Pixel (119,40) and (520,40) = 0.
- fb_valid latency 30 clk: underflow goes to 1, affected pixels show 0, no X or hang. The next line starts cleanly from the correct row address.
- Line start arriving while in WAIT (force stall): the late response is dropped and the new line begins at its correct address.
- rst pulsed at (300,200) with a fetch outstanding: all outputs return to reset values the next clk, and timing restarts from (0,0).
